player_motion_unit: RTL and testbench

Parametrised successor to the player update stage. On each `start` request it computes the player's next pose from the keyboard controls and the direction vector. The controls are forward/back, strafe and turn. It checks collisions per axis against the level grid through a request/valid lookup port, then commits the result. Movement can slide along walls, strafing is supported, and the update rate is limited by a counter. It sits between the frame sequencer, which issues `start` and consumes `done`, and the level-grid memory.

---
 rtl/player_pkg.sv | 32 +++
 rtl/move_rate_limiter.sv | 29 ++
 rtl/player_motion_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_player_motion_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types and constants for the player motion datapath.
package player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREDICT,
    ST_REQ_X,
    ST_WAIT_X,
    ST_REQ_Y,
    ST_WAIT_Y,
    ST_COMMIT,
    ST_DONE
  } motion_state_t;

  localparam logic [2:0] EMPTY = 3'd0;

  localparam int DEF_X_W       = 14;
  localparam int DEF_Y_W       = 13;
  localparam int DEF_ANG_W     = 8;
  localparam int DEF_DIR_W     = 15;
  localparam int DEF_CELL_SHIFT = 8;
  localparam int DEF_GX_W      = 6;
  localparam int DEF_GY_W      = 5;

  // Opposing key pair to a step term: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0.
  function automatic logic [1:0] key_term(input logic pos, input logic neg);
    if (pos && !neg) return 2'b01;
    if (neg && !pos) return 2'b11;
    return 2'b00;
  endfunction

endpackage

// File: rtl/move_rate_limiter.sv
// Down-counter that enforces a minimum spacing between committed moves.
module move_rate_limiter #(
  parameter int PERIOD = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic ready
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  // Load on a committed move, otherwise count down to zero and stay there.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign ready = (count == '0);

endmodule

// File: rtl/player_motion_unit.sv
// Player pose update: predict from controls, check each axis against the
// level grid (X first, then Y from the accepted X for wall sliding), commit.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for start
// PREDICT    | compute turn, displacement and targets; decide lookups
// REQ_X      | strobe grid lookup for the X target cell
// WAIT_X     | wait for the X cell type, accept or reject X
// REQ_Y      | strobe grid lookup for the Y target cell (accepted X column)
// WAIT_Y     | wait for the Y cell type, accept or reject Y
// COMMIT     | publish pose and blocked flags, arm the rate limiter
// DONE       | one-cycle done pulse
module player_motion_unit
  import player_pkg::*;
#(
  parameter int X_W         = DEF_X_W,
  parameter int Y_W         = DEF_Y_W,
  parameter int ANG_W       = DEF_ANG_W,
  parameter int DIR_W       = DEF_DIR_W,
  parameter int CELL_SHIFT  = DEF_CELL_SHIFT,
  parameter int GX_W        = DEF_GX_W,
  parameter int GY_W        = DEF_GY_W,
  parameter int TURN_SPEED  = 2,
  parameter int MOVE_PERIOD = 5000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             turn_right,
  input  logic             turn_left,
  input  logic             move_forward,
  input  logic             move_backward,
  input  logic             strafe_right,
  input  logic             strafe_left,
  input  logic [X_W-1:0]   cur_pos_x,
  input  logic [Y_W-1:0]   cur_pos_y,
  input  logic [ANG_W-1:0] cur_angle,
  input  logic [DIR_W-1:0] dir_x,
  input  logic [DIR_W-1:0] dir_y,
  output logic             grid_req,
  output logic [GX_W-1:0]  grid_x,
  output logic [GY_W-1:0]  grid_y,
  input  logic             grid_valid,
  input  logic [2:0]       grid_out,
  output logic [X_W-1:0]   next_pos_x,
  output logic [Y_W-1:0]   next_pos_y,
  output logic [ANG_W-1:0] next_angle,
  output logic             blocked_x,
  output logic             blocked_y,
  output logic             busy,
  output logic             done
);

  localparam int DX_W = DIR_W + 1;
  // Target width leaves headroom for sign and for overshoot above 2^W.
  localparam int SX_W = ((X_W > DX_W) ? X_W : DX_W) + 2;
  localparam int SY_W = ((Y_W > DX_W) ? Y_W : DX_W) + 2;

  motion_state_t state, state_n;

  logic [1:0]             t_term, f_term, s_term;
  logic signed [DX_W-1:0] dir_x_e, dir_y_e, disp_x, disp_y;
  logic signed [SX_W-1:0] tgt_x_s;
  logic signed [SY_W-1:0] tgt_y_s;
  logic                   out_x, out_y;
  logic [ANG_W-1:0]       turn_angle;

  logic [X_W-1:0]   acc_x, tgt_x;
  logic [Y_W-1:0]   acc_y, tgt_y;
  logic [ANG_W-1:0] tmp_angle;
  logic             blk_x, blk_y, need_y, throttled;
  logic             rate_ready, load_rate, pose_changed;

  function automatic logic signed [DX_W-1:0] scale(input logic [1:0] k,
                                                   input logic signed [DX_W-1:0] v);
    if (k == 2'b01) return v;
    if (k == 2'b11) return -v;
    return '0;
  endfunction

  move_rate_limiter #(.PERIOD(MOVE_PERIOD)) u_rate (
    .clock (clock),
    .reset (reset),
    .load  (load_rate),
    .ready (rate_ready)
  );

  // Prediction: turn, displacement and range check of each axis target.
  always_comb begin
    t_term  = key_term(turn_right, turn_left);
    f_term  = key_term(move_forward, move_backward);
    s_term  = key_term(strafe_right, strafe_left);
    dir_x_e = {dir_x[DIR_W-1], dir_x};
    dir_y_e = {dir_y[DIR_W-1], dir_y};
    disp_x  = scale(f_term, dir_x_e) - scale(s_term, dir_y_e);
    disp_y  = scale(f_term, dir_y_e) + scale(s_term, dir_x_e);
    tgt_x_s = $signed({{(SX_W-X_W){1'b0}}, cur_pos_x}) + SX_W'(disp_x);
    tgt_y_s = $signed({{(SY_W-Y_W){1'b0}}, cur_pos_y}) + SY_W'(disp_y);
    out_x   = |tgt_x_s[SX_W-1:X_W];
    out_y   = |tgt_y_s[SY_W-1:Y_W];
    case (t_term)
      2'b01:   turn_angle = cur_angle + ANG_W'(TURN_SPEED);
      2'b11:   turn_angle = cur_angle - ANG_W'(TURN_SPEED);
      default: turn_angle = cur_angle;
    endcase
  end

  assign pose_changed = (tmp_angle != cur_angle) || (acc_x != cur_pos_x) ||
                        (acc_y != cur_pos_y);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state and control strobes.
  always_comb begin
    state_n   = state;
    grid_req  = 1'b0;
    done      = 1'b0;
    load_rate = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE:    if (start) state_n = ST_PREDICT;
      ST_PREDICT: begin
        if (!rate_ready)                         state_n = ST_COMMIT;
        else if ((disp_x != '0) && !out_x)       state_n = ST_REQ_X;
        else if ((disp_y != '0) && !out_y)       state_n = ST_REQ_Y;
        else                                     state_n = ST_COMMIT;
      end
      ST_REQ_X: begin
        grid_req = 1'b1;
        state_n  = ST_WAIT_X;
      end
      ST_WAIT_X:  if (grid_valid) state_n = need_y ? ST_REQ_Y : ST_COMMIT;
      ST_REQ_Y: begin
        grid_req = 1'b1;
        state_n  = ST_WAIT_Y;
      end
      ST_WAIT_Y:  if (grid_valid) state_n = ST_COMMIT;
      ST_COMMIT: begin
        load_rate = !throttled && pose_changed;
        state_n   = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default:    state_n = ST_IDLE;
    endcase
  end

  // Lookup address follows the state so it stays put from request to result.
  always_comb begin
    grid_x = '0;
    grid_y = '0;
    if (state == ST_REQ_X || state == ST_WAIT_X) begin
      grid_x = GX_W'(tgt_x >> CELL_SHIFT);
      grid_y = GY_W'(cur_pos_y >> CELL_SHIFT);
    end else if (state == ST_REQ_Y || state == ST_WAIT_Y) begin
      grid_x = GX_W'(acc_x >> CELL_SHIFT);
      grid_y = GY_W'(tgt_y >> CELL_SHIFT);
    end
  end

  // Working pose, per-axis accept/reject and the committed outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_x      <= '0;
      acc_y      <= '0;
      tgt_x      <= '0;
      tgt_y      <= '0;
      tmp_angle  <= '0;
      blk_x      <= 1'b0;
      blk_y      <= 1'b0;
      need_y     <= 1'b0;
      throttled  <= 1'b0;
      next_pos_x <= '0;
      next_pos_y <= '0;
      next_angle <= '0;
      blocked_x  <= 1'b0;
      blocked_y  <= 1'b0;
    end else begin
      case (state)
        ST_PREDICT: begin
          tmp_angle <= rate_ready ? turn_angle : cur_angle;
          acc_x     <= cur_pos_x;
          acc_y     <= cur_pos_y;
          tgt_x     <= tgt_x_s[X_W-1:0];
          tgt_y     <= tgt_y_s[Y_W-1:0];
          throttled <= !rate_ready;
          blk_x     <= rate_ready && out_x;
          blk_y     <= rate_ready && out_y;
          need_y    <= rate_ready && (disp_y != '0) && !out_y;
        end
        ST_WAIT_X: begin
          if (grid_valid) begin
            if (grid_out == EMPTY) acc_x <= tgt_x;
            else                   blk_x <= 1'b1;
          end
        end
        ST_WAIT_Y: begin
          if (grid_valid) begin
            if (grid_out == EMPTY) acc_y <= tgt_y;
            else                   blk_y <= 1'b1;
          end
        end
        ST_COMMIT: begin
          next_pos_x <= acc_x;
          next_pos_y <= acc_y;
          next_angle <= tmp_angle;
          blocked_x  <= blk_x;
          blocked_y  <= blk_y;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_player_motion_unit.sv
// Scoreboard bench for player_motion_unit with a behavioural level-grid memory.
module tb_player_motion_unit;
  import player_pkg::*;

  localparam int MP = 4;

  typedef struct {
    int nx; int ny; int na; int bx; int by;
    int lat; int nlook; int l0; int l1;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset, start;
  logic        turn_right, turn_left, move_forward, move_backward;
  logic        strafe_right, strafe_left;
  logic [13:0] cur_pos_x;
  logic [12:0] cur_pos_y;
  logic [7:0]  cur_angle;
  logic [14:0] dir_x, dir_y;
  logic        grid_req;
  logic [5:0]  grid_x;
  logic [4:0]  grid_y;
  logic        grid_valid;
  logic [2:0]  grid_out;
  logic [13:0] next_pos_x;
  logic [12:0] next_pos_y;
  logic [7:0]  next_angle;
  logic        blocked_x, blocked_y, busy, done;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int grid_lat  = 1;
  int look_cnt  = 0;
  int last_load = -1000;

  logic [2:0] grid_map [64][32];
  exp_t sb_q[$];
  int   look_q[$];

  localparam logic [5:0] K_NONE = 6'b000000;
  localparam logic [5:0] K_TR   = 6'b100000;
  localparam logic [5:0] K_TL   = 6'b010000;
  localparam logic [5:0] K_FWD  = 6'b001000;
  localparam logic [5:0] K_BWD  = 6'b000100;
  localparam logic [5:0] K_SR   = 6'b000010;

  player_motion_unit #(.MOVE_PERIOD(MP)) dut (
    .clock(clock), .reset(reset), .start(start),
    .turn_right(turn_right), .turn_left(turn_left),
    .move_forward(move_forward), .move_backward(move_backward),
    .strafe_right(strafe_right), .strafe_left(strafe_left),
    .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y), .cur_angle(cur_angle),
    .dir_x(dir_x), .dir_y(dir_y),
    .grid_req(grid_req), .grid_x(grid_x), .grid_y(grid_y),
    .grid_valid(grid_valid), .grid_out(grid_out),
    .next_pos_x(next_pos_x), .next_pos_y(next_pos_y), .next_angle(next_angle),
    .blocked_x(blocked_x), .blocked_y(blocked_y), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_map();
    foreach (grid_map[i, j]) grid_map[i][j] = 3'd0;
  endtask

  function automatic int term(input logic p, input logic n);
    if (p && !n) return 1;
    if (n && !p) return -1;
    return 0;
  endfunction

  // Reference model of one update given the bench's grid contents.
  function automatic exp_t model(input int cx, input int cy, input int ca,
                                 input int ddx, input int ddy,
                                 input logic [5:0] k, input bit thr);
    exp_t e;
    int t, f, s, mx, my, tx, ty, ax, ay, lk;
    bit ox, oy;
    e = '{default: 0};
    e.lat = 3;
    if (thr) begin
      e.nx = cx; e.ny = cy; e.na = ca;
      return e;
    end
    t = term(k[5], k[4]);
    f = term(k[3], k[2]);
    s = term(k[1], k[0]);
    e.na = (ca + t * 2) & 255;
    mx = f * ddx - s * ddy;
    my = f * ddy + s * ddx;
    tx = cx + mx;
    ty = cy + my;
    ox = (tx < 0) || (tx >= 16384);
    oy = (ty < 0) || (ty >= 8192);
    ax = cx; ay = cy;
    e.bx = ox; e.by = oy;
    if (mx != 0 && !ox) begin
      e.l0 = (tx >> 8) * 100 + (cy >> 8);
      e.nlook = 1;
      e.lat += 1 + grid_lat;
      if (grid_map[tx >> 8][cy >> 8] == 3'd0) ax = tx;
      else e.bx = 1;
    end
    if (my != 0 && !oy) begin
      lk = (ax >> 8) * 100 + (ty >> 8);
      if (e.nlook == 0) e.l0 = lk;
      else e.l1 = lk;
      e.nlook++;
      e.lat += 1 + grid_lat;
      if (grid_map[ax >> 8][ty >> 8] == 3'd0) ay = ty;
      else e.by = 1;
    end
    e.nx = ax; e.ny = ay;
    return e;
  endfunction

  // Grid memory: answers each request after grid_lat cycles, checks the cell.
  initial begin
    int gx, gy, ex;
    grid_valid = 1'b0;
    grid_out   = 3'd0;
    forever begin
      @(negedge clock);
      if (grid_req === 1'b1) begin
        gx = int'(grid_x);
        gy = int'(grid_y);
        look_cnt++;
        if (look_q.size() != 0) begin
          ex = look_q.pop_front();
          check_eq("grid_cell", gx * 100 + gy, ex);
        end
        repeat (grid_lat) @(posedge clock);
        #1;
        grid_valid = 1'b1;
        grid_out   = grid_map[gx][gy];
        @(posedge clock);
        #1;
        grid_valid = 1'b0;
        grid_out   = 3'd0;
      end
    end
  end

  task automatic drive_pose(input int cx, input int cy, input int ca,
                            input int ddx, input int ddy, input logic [5:0] k);
    cur_pos_x = 14'(cx);
    cur_pos_y = 13'(cy);
    cur_angle = 8'(ca);
    dir_x     = 15'(ddx);
    dir_y     = 15'(ddy);
    {turn_right, turn_left, move_forward, move_backward, strafe_right, strafe_left} = k;
  endtask

  task automatic run_update(input string name, input int cx, input int cy, input int ca,
                            input int ddx, input int ddy, input logic [5:0] k);
    exp_t e, g;
    int n, lc0;
    bit thr, seen;
    @(posedge clock);
    #1;
    check_eq({name, "_idle_busy"}, busy, 0);
    drive_pose(cx, cy, ca, ddx, ddy, k);
    start = 1'b1;
    n   = cyc;
    thr = (n + 1) < (last_load + MP);
    e   = model(cx, cy, ca, ddx, ddy, k, thr);
    sb_q.push_back(e);
    if (e.nlook >= 1) look_q.push_back(e.l0);
    if (e.nlook >= 2) look_q.push_back(e.l1);
    lc0 = look_cnt;
    @(posedge clock);
    #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (done === 1'b1) seen = 1'b1;
    end
    g = sb_q.pop_front();
    check_eq({name, "_done_seen"}, seen, 1);
    check_eq({name, "_latency"}, cyc - n, g.lat);
    check_eq({name, "_next_x"}, next_pos_x, g.nx);
    check_eq({name, "_next_y"}, next_pos_y, g.ny);
    check_eq({name, "_next_angle"}, next_angle, g.na);
    check_eq({name, "_blocked_x"}, blocked_x, g.bx);
    check_eq({name, "_blocked_y"}, blocked_y, g.by);
    check_eq({name, "_lookups"}, look_cnt - lc0, g.nlook);
    check_eq({name, "_busy_in_done"}, busy, 1);
    if (!thr && (g.nx != cx || g.ny != cy || g.na != ca)) last_load = n + g.lat - 1;
  endtask

  initial begin
    int reqs;
    reset = 1'b0;
    start = 1'b0;
    drive_pose(0, 0, 0, 0, 0, K_NONE);
    clear_map();
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_next_x", next_pos_x, 0);
    check_eq("rst_next_angle", next_angle, 0);
    check_eq("rst_blocked", {blocked_x, blocked_y}, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_grid_req", grid_req, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    run_update("fwd_open", 1000, 1000, 0, 40, 0, K_FWD);
    repeat (4) @(posedge clock);
    run_update("diag_open", 1000, 1000, 0, 40, 30, K_FWD);
    repeat (4) @(posedge clock);

    grid_map[4][3] = 3'd1;
    run_update("wall_slide", 1020, 1000, 0, 40, 30, K_FWD);
    repeat (4) @(posedge clock);
    grid_lat = 2;
    run_update("slow_grid_slide", 1020, 1000, 0, 40, 30, K_FWD);
    grid_lat = 1;
    clear_map();
    grid_map[7][8] = 3'd5;
    repeat (4) @(posedge clock);
    run_update("back_strafe", 2000, 2000, 9, 40, 30, K_BWD | K_SR);
    clear_map();

    repeat (4) @(posedge clock);
    run_update("turn_wrap_r", 500, 500, 255, 40, 30, K_TR);
    repeat (4) @(posedge clock);
    run_update("turn_wrap_l", 500, 500, 1, 40, 30, K_TL);
    repeat (4) @(posedge clock);
    run_update("turn_both", 500, 500, 77, 40, 30, K_TR | K_TL);
    run_update("no_keys", 500, 500, 77, 40, 30, K_NONE);

    repeat (4) @(posedge clock);
    run_update("underflow_x", 10, 1000, 0, -40, 0, K_FWD);
    repeat (4) @(posedge clock);
    run_update("overflow_y", 1000, 8180, 0, 0, 40, K_FWD);

    repeat (4) @(posedge clock);
    run_update("rate_move", 3000, 3000, 0, 40, 0, K_FWD);
    run_update("rate_throttled", 3040, 3000, 0, 40, 0, K_FWD | K_TR);
    run_update("rate_released", 3040, 3000, 0, 40, 0, K_FWD);

    // Reset while waiting on the Y lookup; the late grid answer must be ignored.
    repeat (4) @(posedge clock);
    grid_lat = 4;
    @(posedge clock);
    #1;
    drive_pose(1000, 1000, 0, 40, 30, K_FWD);
    start = 1'b1;
    look_q.push_back(403);
    look_q.push_back(404);
    @(posedge clock);
    #1;
    start = 1'b0;
    reqs = 0;
    for (int i = 0; i < 60 && reqs < 2; i++) begin
      @(negedge clock);
      if (grid_req === 1'b1) reqs++;
    end
    check_eq("rst_reached_wait_y", reqs, 2);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_grid_req", grid_req, 0);
    check_eq("midrst_next_x", next_pos_x, 0);
    check_eq("midrst_next_y", next_pos_y, 0);
    check_eq("midrst_blocked", {blocked_x, blocked_y}, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    last_load = -1000;
    sb_q.delete();
    look_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check_eq("late_valid_busy", busy, 0);
      check_eq("late_valid_next_x", next_pos_x, 0);
    end
    grid_lat = 1;
    repeat (2) @(posedge clock);
    run_update("after_reset", 1000, 1000, 10, 40, 0, K_FWD | K_TR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
    $fatal(1, "bench timed out");
  end

endmodule
